// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings and the
// wait-counter limits, also consumed by the core's stall controller.
package data_memory_responder_pkg;

  localparam int BUS_ADDR_W  = 32;
  localparam int CNT_W       = 4;
  localparam int LATENCY_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } dm_state_e;

  // Counter preload on acceptance; WAIT exits when the counter reaches zero.
  function automatic logic [CNT_W-1:0] latency_load(input int latency);
    return (latency == 0) ? '0 : CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core-to-data-memory bus: word-addressed read/write request with a ready pulse,
// busy indication and per-response error flag.
interface data_memory_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                                          mem_read;
    logic                                          mem_write;
    logic [data_memory_responder_pkg::BUS_ADDR_W-1:0] address;
    logic [DATA_WIDTH-1:0]                         write_data;
    logic [DATA_WIDTH-1:0]                         read_data;
    logic                                          ready;
    logic                                          busy;
    logic                                          error;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, ready, busy, error
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, ready, busy, error
    );
endinterface

// File: rtl/data_memory_responder_dm_storage.sv
// Single-port synchronous RAM for the data-memory responder: write-enable port and a
// registered read port with a synchronous clear used for rejected requests.
module dm_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register is reset so read_data starts at zero and holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY cycles, then
// pulses ready for one cycle while performing the access. Flags illegal requests.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_responder_if.slave  bus
);

    if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_memory_responder: LATENCY must be in 0..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH >= BUS_ADDR_W) begin : g_bad_addr_width
        $error("data_memory_responder: ADDR_WIDTH must be in 1..31");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = latency_load(LATENCY);

    typedef struct packed {
        logic                  op_write;
        logic                  illegal;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    dm_state_e         state;
    dm_state_e         state_next;
    logic [CNT_W-1:0]  wait_cnt;
    req_t              req_in;
    req_t              req_q;
    req_t              req_cur;
    logic              req_seen;
    logic              acc_en;
    logic              wr_en;
    logic              rd_en;
    logic              ready;
    logic              busy;
    logic              error;

    assign req_seen = bus.mem_read | bus.mem_write;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_in          = '0;
        req_in.op_write = bus.mem_write;
        req_in.illegal  = (bus.mem_read & bus.mem_write) |
                          (bus.address[BUS_ADDR_W-1:ADDR_WIDTH] != '0);
        req_in.addr     = bus.address[ADDR_WIDTH-1:0];
        req_in.wdata    = bus.write_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_seen) begin
                    state_next = (LATENCY == 0) ? ST_RESPOND : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        error = 1'b0;
        case (state)
            ST_WAIT: busy = 1'b1;
            ST_RESPOND: begin
                ready = 1'b1;
                busy  = 1'b1;
                error = req_q.illegal;
            end
            default: ;
        endcase
    end

    // Request capture and wait counter; inputs are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            req_q    <= '0;
        end else if (state == ST_IDLE && req_seen) begin
            wait_cnt <= LAT_LOAD;
            req_q    <= req_in;
        end else if (state == ST_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // The access happens on the edge that enters RESPOND, so read_data is already valid
    // with ready. With zero latency that edge is the acceptance edge, so the live request
    // is used while still in IDLE. Gating with rst_n keeps a reset from committing a write.
    assign req_cur = (state == ST_IDLE) ? req_in : req_q;
    assign acc_en  = rst_n & (state_next == ST_RESPOND);
    assign wr_en   = acc_en & req_cur.op_write & ~req_cur.illegal;
    assign rd_en   = acc_en & (~req_cur.op_write | req_cur.illegal);

    dm_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .re     (rd_en),
        .rd_clr (req_cur.illegal),
        .addr   (req_cur.addr),
        .wdata  (req_cur.wdata),
        .rdata  (bus.read_data)
    );

    assign bus.ready = ready;
    assign bus.busy  = busy;
    assign bus.error = error;

endmodule
